dmem_access_seq: RTL and testbench
==================================

Name: dmem_access_seq

Overview:
- Data-memory access sequencer between the memory stage and the single-port, byte-masked DMEM (synchronous read, 1-cycle latency).
- Converts each load/store request into a word address, write-byte mask and lane-shifted write data.
- Accesses that cross a 32-bit word boundary are split into two DMEM cycles, with `stall` held while the split is issued.
- Load data is returned right-justified and sign/zero-extended.

Parameters:
DMEM_AW, 14, DMEM word-address width; `dmem_addr = addr[DMEM_AW+1:2]`.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory-stage request present. Held stable by the pipeline while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 is treated as word.
- req_signed  in  1  load sign-extend (inverse of funct3[2]).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- dmem_en  out  1  DMEM access this cycle.
- dmem_addr  out  DMEM_AW  word address.
- dmem_we  out  4  byte write mask; bit i covers byte lane i.
- dmem_din  out  32  lane-shifted write data.
- dmem_dout  in  32  DMEM read data, valid the cycle after dmem_en with dmem_we=0.
- stall  out  1  hold the pipeline; the request is re-presented next cycle.
- rsp_valid  out  1  load data valid this cycle.
- rsp_rdata  out  32  extended load data.
- misalign_trap  out  1  misaligned access flagged (see Optional Feature); tied 0 otherwise.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0.
  - Latched request and pending response cleared.
  - Reset mid-split aborts the split: no second DMEM cycle and no rsp_valid.
- Offset definitions:
  - off = req_addr[1:0].
  - A request is misaligned iff (size=half and off=3) or (size=word and off≠0).
  - Byte requests are never misaligned.
- IDLE, req_valid=0:
  - dmem_en=0, stall=0.
- IDLE, aligned request:
  - dmem_en=1, dmem_addr=addr word.
  - Mask for stores: byte = 0001<<off; half = 0011<<off; word = 1111.
  - Loads: mask=0000.
  - dmem_din=wdata<<(8*off).
  - stall=0; stay IDLE.
  - If load: set rsp_pending for the next cycle.
- IDLE, misaligned request:
  - Issue the low part: dmem_addr=word(addr), din=wdata<<(8*off).
  - Low masks:
    - word off1 → 1110
    - word off2 → 1100
    - word off3 → 1000
    - half off3 → 1000
  - stall=1.
  - Latch addr, size, signed, we, wdata, off.
  - Go to SPLIT.
- SPLIT:
  - Ignore request inputs.
  - Issue the high part: dmem_addr = latched word + 1, wrapping modulo 2^DMEM_AW.
  - din = wdata>>(8*(4-off)).
  - High masks:
    - word off1 → 0001
    - word off2 → 0011
    - word off3 → 0111
    - half off3 → 0001
  - If load: register dmem_dout as lo_word and set rsp_pending.
  - stall=0; go to IDLE.
  - A new request in the following IDLE cycle is accepted normally.
- Response cycle (rsp_pending=1, the cycle after the final DMEM issue):
  - rsp_valid=1.
  - Form raw = ({dmem_dout, lo_word} >> (8*off)) for split loads, or dmem_dout >> (8*off) for aligned loads.
  - Extend by size/signed: byte bits[7:0], half bits[15:0], word unchanged.
  - rsp_valid lasts exactly 1 cycle.
  - It may coincide with a new request being issued in IDLE; both proceed.
- Latency:
  - Aligned: 1 DMEM cycle, 0 stall cycles, load data at +1.
  - Misaligned: 2 DMEM cycles, 1 stall cycle, load data at +2 from first issue.
- Address wrap: 0x...FFFF_FFFE word access splits into the top word and word 0.

Optional Feature:
- Macro `DMEM_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned requests never split and SPLIT is unreachable.
  - dmem_en=0, dmem_we=0, stall=0.
  - misalign_trap=1 for that cycle; no rsp_valid.
- Undefined:
  - Split behaviour as above; misalign_trap is constant 0.

Decomposition:
- Shared header `DmemSeq.vh`: size encodings SZ_B/SZ_H/SZ_W and state encodings IDLE/SPLIT.
- One natural combinational sub-module, `dmem_lane_align`:
  - Inputs: size, off, part (lo/hi), we.
  - Outputs: mask and shifted din.
  - Instantiated once, with part selected by state.
- Load extraction stays in the top level.

Test Plan:
- Reset asserted during SPLIT of SW at 0x101 → next cycle: dmem_en=0, no rsp_valid, state IDLE after release.
- SB 0x000000AB at 0x102 → dmem_addr=0x40, we=0100, din=0x00AB0000, stall=0.
- SW 0x11223344 at 0x201 → cycle0: addr 0x80, we=1110, din=0x22334400, stall=1; cycle1: addr 0x81, we=0001, din=0x00000011, stall=0.
- LH signed at 0x103, mem[0x40]=0xAABBCCDD, mem[0x41]=0x00000080 → two reads, rsp_rdata=0xFFFF80AA at +2.
- LBU at 0x3 (mem word 0x7F000000) back-to-back with LW at 0x4 → rsp 0x0000007F then next cycle the LW word; no stall.
- With DMEM_MISALIGN_TRAP_EN: LW at 0x6 → misalign_trap=1, dmem_en=0, stall=0, no rsp_valid.

Source files
------------

// File: rtl/dmem_access_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_access_seq_pkg
// Description : Shared size encodings, sequencer states, lane-part selector
//               and small decode helpers for the DMEM access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_seq_pkg;

    // Access size encodings (funct3[1:0]); 2'b11 is folded onto word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Sequencer states: IDLE accepts requests, SPLIT issues the high half.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } seqState_t;

    // Which DMEM word of a (possibly split) access is being formed.
    typedef enum logic [0:0] {
        PART_LO = 1'b0,
        PART_HI = 1'b1
    } lanePart_t;

    // Fold the reserved size code onto word.
    function automatic logic [1:0] normSize(input logic [1:0] size);
        return (size == 2'b11) ? SZ_W : size;
    endfunction

    // Half at offset 3 or any unaligned word spills into the next word.
    function automatic logic isMisaligned(input logic [1:0] size,
                                          input logic [1:0] off);
        logic [1:0] s;
        s = normSize(size);
        return ((s == SZ_H) && (off == 2'd3)) || ((s == SZ_W) && (off != 2'd0));
    endfunction

    // Byte-enable pattern of an access before lane shifting.
    function automatic logic [3:0] sizeMask(input logic [1:0] size);
        logic [3:0] m;
        case (normSize(size))
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage : dmem_access_seq_pkg
`default_nettype wire

// File: rtl/dmem_access_seq_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational lane aligner. Shifts the size mask and store
//               data into a 64-bit two-word window by the byte offset and
//               returns either the low or the high word of that window.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_access_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  lanePart_t   part,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] din
);

    logic [3:0]  w_baseMask;
    logic [7:0]  w_maskWin;
    logic [63:0] w_dataWin;

    // Shift into a two-word window; the low word is the first DMEM cycle and
    // the high word is whatever spilled past the word boundary.
    always_comb begin
        w_baseMask = sizeMask(size);
        w_maskWin  = {4'b0000, w_baseMask} << off;
        w_dataWin  = {32'h0000_0000, wdata} << {off, 3'b000};
        mask       = 4'b0000;
        din        = w_dataWin[31:0];
        if (part == PART_HI) begin
            din = w_dataWin[63:32];
            if (we) begin
                mask = w_maskWin[7:4];
            end
        end else if (we) begin
            mask = w_maskWin[3:0];
        end
    end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/dmem_access_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_access_seq
// Description : Data-memory access sequencer. Turns memory-stage load/store
//               requests into word-addressed, byte-masked DMEM cycles,
//               splitting word-crossing accesses into two cycles, and returns
//               right-justified, sign/zero-extended load data.
// Options     : `DMEM_MISALIGN_TRAP_EN - flag misaligned requests on
//               misalign_trap instead of splitting them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_seq
    import dmem_access_seq_pkg::*;
#(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               dmem_en,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic               stall,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               misalign_trap
);

    // ---------------------------------------------------------------- state
    seqState_t          r_state;

    // Request latched for the high half of a split access.
    logic [DMEM_AW-1:0] r_latWord;
    logic [1:0]         r_latSize;
    logic [1:0]         r_latOff;
    logic               r_latSigned;
    logic               r_latWe;
    logic [31:0]        r_latWdata;

    // Pending load response and the low word of a split load.
    logic               r_rspPending;
    logic               r_rspSplit;
    logic               r_rspSigned;
    logic [1:0]         r_rspSize;
    logic [1:0]         r_rspOff;
    logic [31:0]        r_loWord;

    // -------------------------------------------------------- request decode
    logic [1:0]         w_reqOff;
    logic [1:0]         w_reqSize;
    logic               w_reqMis;
    logic               w_accept;
    logic               w_doSplit;
    logic               w_trap;

    assign w_reqOff  = req_addr[1:0];
    assign w_reqSize = normSize(req_size);
    assign w_reqMis  = isMisaligned(req_size, w_reqOff);
    assign w_accept  = (r_state == IDLE) && req_valid;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_trap    = w_accept && w_reqMis;
    assign w_doSplit = 1'b0;
`else
    assign w_trap    = 1'b0;
    assign w_doSplit = w_accept && w_reqMis;
`endif

    // ------------------------------------------------------ lane alignment
    logic [1:0]         w_alSize;
    logic [1:0]         w_alOff;
    lanePart_t          w_alPart;
    logic               w_alWe;
    logic [31:0]        w_alWdata;
    logic [DMEM_AW-1:0] w_wordAddr;
    logic               w_issue;
    logic [3:0]         w_alMask;
    logic [31:0]        w_alDin;

    // Select live request (IDLE) or latched request (SPLIT) for the aligner.
    always_comb begin
        w_alSize   = w_reqSize;
        w_alOff    = w_reqOff;
        w_alPart   = PART_LO;
        w_alWe     = req_we;
        w_alWdata  = req_wdata;
        w_wordAddr = req_addr[DMEM_AW+1:2];
        w_issue    = w_accept && !w_trap;
        if (r_state == SPLIT) begin
            w_alSize   = r_latSize;
            w_alOff    = r_latOff;
            w_alPart   = PART_HI;
            w_alWe     = r_latWe;
            w_alWdata  = r_latWdata;
            w_wordAddr = r_latWord + DMEM_AW'(1);
            w_issue    = 1'b1;
        end
    end

    dmem_lane_align u_laneAlign (
        .size  (w_alSize),
        .off   (w_alOff),
        .part  (w_alPart),
        .we    (w_alWe),
        .wdata (w_alWdata),
        .mask  (w_alMask),
        .din   (w_alDin)
    );

    // DMEM-side outputs; held at zero whenever no access is issued or while
    // reset is asserted.
    always_comb begin
        dmem_en       = rst_n & w_issue;
        dmem_addr     = '0;
        dmem_we       = 4'b0000;
        dmem_din      = 32'h0000_0000;
        if (dmem_en) begin
            dmem_addr = w_wordAddr;
            dmem_we   = w_alMask;
            dmem_din  = w_alDin;
        end
        stall         = rst_n & w_doSplit;
        misalign_trap = rst_n & w_trap;
    end

    // Sequencer: split control, request latch and load-response bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_latWord    <= '0;
            r_latSize    <= SZ_B;
            r_latOff     <= 2'd0;
            r_latSigned  <= 1'b0;
            r_latWe      <= 1'b0;
            r_latWdata   <= 32'h0000_0000;
            r_rspPending <= 1'b0;
            r_rspSplit   <= 1'b0;
            r_rspSigned  <= 1'b0;
            r_rspSize    <= SZ_B;
            r_rspOff     <= 2'd0;
            r_loWord     <= 32'h0000_0000;
        end else begin
            r_rspPending <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_doSplit) begin
                        r_latWord   <= req_addr[DMEM_AW+1:2];
                        r_latSize   <= w_reqSize;
                        r_latOff    <= w_reqOff;
                        r_latSigned <= req_signed;
                        r_latWe     <= req_we;
                        r_latWdata  <= req_wdata;
                        r_state     <= SPLIT;
                    end else if (w_accept && !w_trap && !req_we) begin
                        r_rspPending <= 1'b1;
                        r_rspSplit   <= 1'b0;
                        r_rspSize    <= w_reqSize;
                        r_rspSigned  <= req_signed;
                        r_rspOff     <= w_reqOff;
                    end
                end
                SPLIT: begin
                    // Low-word read data returns while the high half issues.
                    if (!r_latWe) begin
                        r_loWord     <= dmem_dout;
                        r_rspPending <= 1'b1;
                        r_rspSplit   <= 1'b1;
                        r_rspSize    <= r_latSize;
                        r_rspSigned  <= r_latSigned;
                        r_rspOff     <= r_latOff;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ load extraction
    logic [63:0] w_rspWin;
    logic [63:0] w_rspShift;
    logic [31:0] w_rspRaw;

    // Right-justify the loaded bytes and extend them to 32 bits.
    always_comb begin
        w_rspWin   = r_rspSplit ? {dmem_dout, r_loWord} : {32'h0000_0000, dmem_dout};
        w_rspShift = w_rspWin >> {r_rspOff, 3'b000};
        w_rspRaw   = w_rspShift[31:0];
        case (r_rspSize)
            SZ_B:    rsp_rdata = {{24{r_rspSigned & w_rspRaw[7]}},  w_rspRaw[7:0]};
            SZ_H:    rsp_rdata = {{16{r_rspSigned & w_rspRaw[15]}}, w_rspRaw[15:0]};
            default: rsp_rdata = w_rspRaw;
        endcase
        if (!r_rspPending) begin
            rsp_rdata = 32'h0000_0000;
        end
    end

    assign rsp_valid = r_rspPending;

    // Address bits above the DMEM window and the spilled half of the
    // response window carry no information.
    logic w_unused;
    assign w_unused = &{1'b0, req_addr[31:DMEM_AW+2], w_rspShift[63:32]};

endmodule : dmem_access_seq
`default_nettype wire

// File: tb/tb_dmem_access_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_seq
// Description : Self-checking bench for dmem_access_seq with a behavioural
//               DMEM, a byte-level reference memory and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_seq;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          dmem_en;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_we;
    logic [31:0]   dmem_din;
    logic [31:0]   dmem_dout = 32'h0;
    logic          stall;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          misalign_trap;

    always #5 clk = ~clk;

    dmem_access_seq #(.DMEM_AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .dmem_en       (dmem_en),
        .dmem_addr     (dmem_addr),
        .dmem_we       (dmem_we),
        .dmem_din      (dmem_din),
        .dmem_dout     (dmem_dout),
        .stall         (stall),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .misalign_trap (misalign_trap)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Behavioural single-port DMEM with a backdoor preload port.
    logic [31:0]   dmem [0:(1<<AW)-1];
    logic          bdWe = 1'b0;
    logic [AW-1:0] bdAddr = '0;
    logic [31:0]   bdData = 32'h0;

    always @(posedge clk) begin
        if (bdWe) begin
            dmem[bdAddr] <= bdData;
        end else if (dmem_en) begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) dmem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
            if (dmem_we == 4'b0000) dmem_dout <= dmem[dmem_addr];
        end
    end

    // Reference memory updated from the requests themselves.
    logic [31:0] refm [0:(1<<AW)-1];

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refm[a[AW+1:2]][8*a[1:0] +: 8];
    endfunction

    task automatic refWriteByte(input logic [31:0] a, input logic [7:0] d);
        refm[a[AW+1:2]][8*a[1:0] +: 8] = d;
    endtask

    // Response scoreboard.
    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;
    exp_t sbq[$];
    exp_t sbHead;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 data=%h at cycle %0d, required no response", rsp_rdata, cyc);
                end else begin
                    sbHead = sbq.pop_front();
                    if (rsp_rdata !== sbHead.data || cyc != sbHead.due) begin
                        miscompares++;
                        $display("FAIL rsp_%s: got %h at cycle %0d, required %h at cycle %0d",
                                 sbHead.name, rsp_rdata, cyc, sbHead.data, sbHead.due);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
                vectors++;
                miscompares++;
                sbHead = sbq.pop_front();
                $display("FAIL rsp_%s_timeout: got no rsp_valid by cycle %0d, required %h at cycle %0d",
                         sbHead.name, cyc, sbHead.data, sbHead.due);
            end
        end
    end

    task automatic preload(input logic [AW-1:0] wa, input logic [31:0] d);
        refm[wa] = d;
        bdWe = 1'b1; bdAddr = wa; bdData = d;
        @(posedge clk); #1;
        bdWe = 1'b0;
    endtask

    task automatic setReq(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one request through to the end of its DMEM cycles, checking the
    // issue side and queueing the expected load result.
    task automatic doReq(input string nm, input logic we, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        logic mis;
        logic [31:0] ev;
        logic [AW-1:0] wa;
        logic [AW-1:0] wa1;
        int issueCyc;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = ((sz == 2'b01) && (addr[1:0] == 2'd3)) || ((sz[1] == 1'b1) && (addr[1:0] != 2'd0));
        wa  = addr[AW+1:2];
        wa1 = wa + 1'b1;
        ev  = 32'h0;
        setReq(we, sz, sgn, addr, wd);
        @(negedge clk);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) begin
            vectors++;
            if (misalign_trap !== 1'b1 || dmem_en !== 1'b0 || stall !== 1'b0 || dmem_we !== 4'b0000) begin
                miscompares++;
                $display("FAIL %s_trap: got trap=%b en=%b stall=%b we=%b, required trap=1 en=0 stall=0 we=0000",
                         nm, misalign_trap, dmem_en, stall, dmem_we);
            end
            @(posedge clk); #1;
            return;
        end
`endif
        issueCyc = cyc;
        vectors++;
        if (dmem_en !== 1'b1 || stall !== mis || dmem_addr !== wa || misalign_trap !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_issue: got en=%b stall=%b addr=%h trap=%b, required en=1 stall=%b addr=%h trap=0",
                     nm, dmem_en, stall, dmem_addr, misalign_trap, mis, wa);
        end
        if (we) begin
            for (int i = 0; i < n; i++) refWriteByte(addr + 32'(i), wd[8*i +: 8]);
        end else begin
            for (int i = 0; i < n; i++) ev[8*i +: 8] = refByte(addr + 32'(i));
            case (sz)
                2'b00:   if (sgn) ev = {{24{ev[7]}}, ev[7:0]};
                2'b01:   if (sgn) ev = {{16{ev[15]}}, ev[15:0]};
                default: ;
            endcase
            sbq.push_back('{data: ev, due: issueCyc + (mis ? 2 : 1), name: nm});
        end
        @(posedge clk); #1;
        if (mis) begin
            @(negedge clk);
            vectors++;
            if (dmem_en !== 1'b1 || stall !== 1'b0 || dmem_addr !== wa1) begin
                miscompares++;
                $display("FAIL %s_split_hi: got en=%b stall=%b addr=%h, required en=1 stall=0 addr=%h",
                         nm, dmem_en, stall, dmem_addr, wa1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        setReq(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
        @(negedge clk);
        vectors++;
        if (dmem_en !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0 || misalign_trap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got en=%b stall=%b rsp=%b trap=%b, required all 0",
                     dmem_en, stall, rsp_valid, misalign_trap);
        end
        vectors++;
        if (dmem_we !== 4'b0000 || dmem_din !== 32'h0 || dmem_addr !== '0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got we=%b din=%h addr=%h rdata=%h, required all 0",
                     dmem_we, dmem_din, dmem_addr, rsp_rdata);
        end
        idle(1);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_store_byte();
        setReq(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00AB);
        @(negedge clk);
        vectors++;
        if (dmem_en !== 1'b1 || dmem_addr !== 14'h040 || dmem_we !== 4'b0100 ||
            dmem_din !== 32'h00AB_0000 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_0x102: got en=%b addr=%h we=%b din=%h stall=%b, required en=1 addr=040 we=0100 din=00ab0000 stall=0",
                     dmem_en, dmem_addr, dmem_we, dmem_din, stall);
        end
        refWriteByte(32'h0000_0102, 8'hAB);
        @(posedge clk); #1;
        doReq("lbu_0x102", 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0);
        doReq("lw_0x100", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        idle(2);
    endtask

    task automatic test_split_store();
        setReq(1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h1122_3344);
        @(negedge clk);
        vectors++;
        if (dmem_en !== 1'b1 || dmem_addr !== 14'h080 || dmem_we !== 4'b1110 ||
            dmem_din !== 32'h2233_4400 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_split_lo: got en=%b addr=%h we=%b din=%h stall=%b, required en=1 addr=080 we=1110 din=22334400 stall=1",
                     dmem_en, dmem_addr, dmem_we, dmem_din, stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (dmem_en !== 1'b1 || dmem_addr !== 14'h081 || dmem_we !== 4'b0001 ||
            dmem_din !== 32'h0000_0011 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_split_hi: got en=%b addr=%h we=%b din=%h stall=%b, required en=1 addr=081 we=0001 din=00000011 stall=0",
                     dmem_en, dmem_addr, dmem_we, dmem_din, stall);
        end
        for (int i = 0; i < 4; i++) refWriteByte(32'h0000_0201 + 32'(i), 8'(32'h1122_3344 >> (8*i)));
        @(posedge clk); #1;
        doReq("lw_0x201", 1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'h0);
        doReq("lw_0x200", 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        doReq("lw_0x204", 1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
        idle(2);
    endtask

    task automatic test_split_load();
        preload(14'h040, 32'hAABB_CCDD);
        preload(14'h041, 32'h0000_0080);
        doReq("lh_0x103", 1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0);
        idle(1);
        doReq("lhu_0x103", 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0);
        doReq("lw_0x102", 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        preload(14'h000, 32'h7F00_0000);
        preload(14'h001, 32'hCAFE_F00D);
        doReq("lbu_0x3", 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0);
        doReq("lw_0x4", 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
        doReq("lb_0x6", 1'b0, 2'b00, 1'b1, 32'h0000_0006, 32'h0);
        doReq("lw_0x6", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        doReq("lh_0x4", 1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0);
        idle(2);
    endtask

    task automatic test_reset_mid_split();
        preload(14'h040, 32'h5555_5555);
        preload(14'h041, 32'h6666_6666);
        setReq(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h1122_3344);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1 || dmem_we !== 4'b1110) begin
            miscompares++;
            $display("FAIL rst_split_lo: got stall=%b we=%b, required stall=1 we=1110", stall, dmem_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (dmem_en !== 1'b0 || dmem_we !== 4'b0000 || rsp_valid !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_split_abort: got en=%b we=%b rsp=%b stall=%b, required all 0",
                     dmem_en, dmem_we, rsp_valid, stall);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        refWriteByte(32'h0000_0101, 8'h44);
        refWriteByte(32'h0000_0102, 8'h33);
        refWriteByte(32'h0000_0103, 8'h22);
        doReq("lw_rst_lo", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        doReq("lw_rst_hi", 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
        idle(2);
    endtask

    task automatic test_wrap();
        preload(14'h3FFF, 32'h4433_2211);
        preload(14'h0000, 32'h8877_6655);
        doReq("lw_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
        doReq("sh_wrap", 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_A5C3);
        doReq("lw_wrap_top", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
        doReq("lh_wrap", 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0);
        doReq("lw_wrap_w0", 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        idle(2);
    endtask

    task automatic test_misaligned_word();
        preload(14'h001, 32'h0403_0201);
        preload(14'h002, 32'h0807_0605);
        doReq("lw_mis_0x6", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        idle(2);
    endtask

    task automatic test_random();
        for (int w = 0; w < 16; w++) preload(AW'(w), $urandom);
        for (int k = 0; k < 80; k++) begin
            doReq("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 59)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);
    endtask

    initial begin
        repeat (2) begin @(posedge clk); #1; end
        test_reset();
        test_store_byte();
        test_split_store();
        test_split_load();
        test_back_to_back();
        test_reset_mid_split();
        test_wrap();
        test_misaligned_word();
        test_random();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d outstanding responses, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_access_seq
`default_nettype wire
